// File: rtl/pipeline_skid_register_pkg.sv
// Shared types and constants for the elastic pipeline skid register.
package pipeline_skid_register_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

endpackage : pipeline_skid_register_pkg

// File: rtl/pipeline_skid_register_skid_data_reg.sv
// Payload register with load enable and asynchronous active-low clear.
module skid_data_reg #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : skid_data_reg

// File: rtl/pipeline_skid_register.sv
// Elastic valid/ready stage with a two-entry skid buffer; both handshake outputs come from flops.
// Optional stall counter is enabled by defining PIPE_SKID_PERF_EN.
module pipeline_skid_register
   import pipeline_skid_register_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef PIPE_SKID_PERF_EN
 , parameter int unsigned CNT_WIDTH  = 32
`endif
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  flush_i,
   input  logic                  s_valid_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  s_ready_o,
   output logic                  m_valid_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   input  logic                  m_ready_i
`ifdef PIPE_SKID_PERF_EN
 , output logic [CNT_WIDTH-1:0]  stall_count_o
`endif
);

   skid_state_e           state_q, state_d;
   logic                  m_valid_q, s_ready_q;
   logic                  s_fire, m_fire;
   logic                  out_en, out_sel_skid, skid_en;
   logic [DATA_WIDTH-1:0] out_d, out_q, skid_q;

   assign s_fire = s_valid_i && s_ready_q;
   assign m_fire = m_valid_q && m_ready_i;

   // Next-state and register-load decode; flush discards both transfers.
   always_comb begin
      state_d      = state_q;
      out_en       = 1'b0;
      out_sel_skid = 1'b0;
      skid_en      = 1'b0;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (s_fire) begin
                  out_en  = 1'b1;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (s_fire && m_fire) begin
                  out_en = 1'b1;
               end else if (s_fire) begin
                  skid_en = 1'b1;
                  state_d = ST_FULL;
               end else if (m_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (m_fire) begin
                  out_en       = 1'b1;
                  out_sel_skid = 1'b1;
                  state_d      = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign out_d = out_sel_skid ? skid_q : s_data_i;

   // Handshake flags are registered from the next state so they never depend on m_ready_i combinationally.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q   <= ST_EMPTY;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         m_valid_q <= (state_d != ST_EMPTY);
         s_ready_q <= (state_d != ST_FULL);
      end
   end

   skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .en_i    (out_en),
      .d_i     (out_d),
      .q_o     (out_q)
   );

   skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid_reg (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .en_i    (skid_en),
      .d_i     (s_data_i),
      .q_o     (skid_q)
   );

   assign s_ready_o = s_ready_q;
   assign m_valid_o = m_valid_q;
   assign m_data_o  = out_q;

`ifdef PIPE_SKID_PERF_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Saturating stall counter; only reset clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (m_valid_q && !m_ready_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_count_o = cnt_q;
`endif

endmodule : pipeline_skid_register

// File: doc/pipeline_skid_register.md
# pipeline_skid_register

Elastic pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer. It sits between core pipeline stages where the downstream stage can stall. A plain enable-less stage register cannot hold data across a stall; this block accepts a transfer every cycle at full throughput. No combinational path runs from the downstream ready to the upstream ready.

## Interface
- DATA_WIDTH, 64, payload width in bits
- CNT_WIDTH, 32, stall counter width (used only with PIPE_SKID_PERF_EN)
- clk_i  input  1  clock; all state changes on rising edge
- arst_ni  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous flush; discards all held data
- s_valid_i  input  1  upstream data valid
- s_data_i  input  DATA_WIDTH  upstream payload
- s_ready_o  output  1  block can accept upstream data; registered
- m_valid_o  output  1  output register holds valid data
- m_data_o  output  DATA_WIDTH  downstream payload; registered
- m_ready_i  input  1  downstream accepts data
- stall_count_o  output  CNT_WIDTH  output-stall cycle count (PIPE_SKID_PERF_EN only)

## Operation
- The upstream transfer (s_fire) happens when s_valid_i && s_ready_o. The downstream transfer (m_fire) happens when m_valid_o && m_ready_i.
- Storage is one output register (out_q) and one skid register (skid_q).
- States:
  - EMPTY: nothing held.
  - BUSY: out_q valid, skid_q empty.
  - FULL: both out_q and skid_q valid.
- EMPTY: on s_fire, out_q <= s_data_i and go to BUSY. Otherwise stay in EMPTY.
- BUSY:
  - s_fire && m_fire: out_q <= s_data_i; stay in BUSY.
  - s_fire && !m_fire: skid_q <= s_data_i; go to FULL.
  - !s_fire && m_fire: go to EMPTY.
  - Otherwise: hold.
- FULL: s_ready_o is 0. On m_fire, out_q <= skid_q and go to BUSY. Otherwise hold. No new data is accepted in this state.
- Outputs are decoded from registered state:
  - m_valid_o = (state != EMPTY)
  - s_ready_o = (state != FULL)
  - m_data_o = out_q
- flush_i overrides everything: the next state is EMPTY and any s_fire or m_fire in that cycle is discarded. The data registers are not cleared.
- Ordering is strict FIFO. Data is never duplicated or dropped, except by flush or reset.
- An illegal state encoding recovers to EMPTY.

## Timing
- Reset (arst_ni low, asynchronous): state = EMPTY, m_valid_o = 0, m_data_o = 0, s_ready_o = 1, stall_count_o = 0. Skid data resets to 0.
- Latency is 1 cycle from s_fire to m_valid_o when the stage was EMPTY or draining.
- Throughput is one transfer per cycle when m_ready_i is held high.
- s_ready_o depends only on flops. The upstream stage may drop s_valid_i freely; the block never requires s_valid_i to be held.
- Downstream rule: the block holds m_data_o and m_valid_o stable while m_valid_o && !m_ready_i.
- Reset asserted mid-transfer drops all held data immediately. The first accept after release happens on the first rising edge with arst_ni high.

## Configuration
- PIPE_SKID_PERF_EN defined:
  - stall_count_o increments each cycle m_valid_o && !m_ready_i and saturates at all-ones.
  - It is cleared only by reset, not by flush_i.
- PIPE_SKID_PERF_EN undefined: the stall_count_o port and CNT_WIDTH logic are absent, and the block is pure handshake plus data storage.

## Structure
- A shared pipeline package holds the state enum (EMPTY, BUSY, FULL) as a 2-bit typedef and the default DATA_WIDTH constant.
- One sub-module, skid_data_reg: a DATA_WIDTH register with load enable and active-low async reset to 0. It is instantiated twice, once for out_q and once for skid_q.

## Test plan
- Reset then idle: with s_valid_i = 0, m_valid_o = 0, s_ready_o = 1 and m_data_o = 0 hold indefinitely.
- Full throughput: stream 0x1..0x10 with m_ready_i = 1. Outputs appear one cycle later, back-to-back, in order, and s_ready_o never drops.
- Stall fill:
  - With m_ready_i = 0, send 0xA then 0xB. s_ready_o drops the cycle after 0xB is accepted, and m_data_o stays 0xA.
  - Raise m_ready_i. 0xA is accepted, then 0xB, and s_ready_o returns to 1 one cycle after 0xA is taken.
- Random valid/ready: 10k cycles against a scoreboard. Checks: no loss, no duplicates, order kept, m_data_o stable during stalls.
- Flush in FULL: with 0xA/0xB held and s_valid_i = 1, assert flush_i. Next cycle m_valid_o = 0 and s_ready_o = 1, and neither 0xB nor the input word ever appears.
- Perf counter (PIPE_SKID_PERF_EN): 5 stall cycles give stall_count_o = 5. With CNT_WIDTH = 4, 20 stall cycles saturate at 0xF, and the count persists across a flush.
